// File: rtl/niu32_mc_alu.sv
// Multicycle Niu32 ALU: one-cycle simple ops, iterative shift-add MLT and restoring DIV.
// Define NIU32_MC_ALU_FAST_MUL_EN to get a single-cycle combinational MLT instead.
module niu32_mc_alu #(
    parameter int WORD_SIZE  = 32,
    parameter int OP_BITS    = 5,
    parameter int SHAMT_BITS = 5,
    parameter int CNT_BITS   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OP_BITS-1:0]   func,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic [WORD_SIZE-1:0] remainder,
    output logic                 div_zero,
    output logic                 illegal
);

    localparam logic [OP_BITS-1:0] F_SUB = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] F_ADD = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] F_MLT = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] F_DIV = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] F_NOT = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] F_AND = OP_BITS'(5);
    localparam logic [OP_BITS-1:0] F_OR  = OP_BITS'(6);
    localparam logic [OP_BITS-1:0] F_XOR = OP_BITS'(7);
    localparam logic [OP_BITS-1:0] F_SUL = OP_BITS'(8);
    localparam logic [OP_BITS-1:0] F_SSL = OP_BITS'(9);
    localparam logic [OP_BITS-1:0] F_SUR = OP_BITS'(10);
    localparam logic [OP_BITS-1:0] F_SSR = OP_BITS'(11);
    localparam logic [OP_BITS-1:0] F_EQ  = OP_BITS'(16);
    localparam logic [OP_BITS-1:0] F_NEQ = OP_BITS'(17);
    localparam logic [OP_BITS-1:0] F_LT  = OP_BITS'(18);
    localparam logic [OP_BITS-1:0] F_LEQ = OP_BITS'(19);

    localparam logic [2:0] S_IDLE    = 3'd0;
`ifndef NIU32_MC_ALU_FAST_MUL_EN
    localparam logic [2:0] S_MUL     = 3'd1;
`endif
    localparam logic [2:0] S_DIV     = 3'd2;
    localparam logic [2:0] S_DIV_FIX = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]            state;
    logic [CNT_BITS-1:0]   cnt;
    logic [WORD_SIZE-1:0]  op_a;    // multiplicand / dividend-then-quotient
    logic [WORD_SIZE-1:0]  op_b;    // multiplier / divisor magnitude
    logic [WORD_SIZE-1:0]  acc;     // product / partial remainder
    logic                  neg_q;
    logic                  neg_r;

    logic [WORD_SIZE-1:0]  simple_res;
    logic                  simple_ill;
    logic [SHAMT_BITS-1:0] shamt;
    logic [WORD_SIZE:0]    div_shift;
    logic [WORD_SIZE:0]    div_diff;
    logic                  last_iter;

    function automatic logic [WORD_SIZE-1:0] mag(input logic [WORD_SIZE-1:0] v);
        return v[WORD_SIZE-1] ? -v : v;
    endfunction

    assign shamt     = b[SHAMT_BITS-1:0];
    assign div_shift = {acc, op_a[WORD_SIZE-1]};
    assign div_diff  = div_shift - {1'b0, op_b};
    assign last_iter = (cnt == CNT_BITS'(WORD_SIZE - 1));

`ifndef NIU32_MC_ALU_FAST_MUL_EN
    logic [WORD_SIZE-1:0] mul_next;
    assign mul_next = acc + (op_b[0] ? op_a : '0);
`endif

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        simple_res = '0;
        simple_ill = 1'b0;
        case (func)
            F_SUB: simple_res = a - b;
            F_ADD: simple_res = a + b;
            F_MLT: begin
`ifdef NIU32_MC_ALU_FAST_MUL_EN
                simple_res = a * b;
`else
                simple_res = '0;
`endif
            end
            F_DIV: simple_res = '0;
            F_NOT: simple_res = ~a;
            F_AND: simple_res = a & b;
            F_OR:  simple_res = a | b;
            F_XOR: simple_res = a ^ b;
            F_SUL, F_SSL: simple_res = a << shamt;
            F_SUR: simple_res = a >> shamt;
            F_SSR: simple_res = $signed(a) >>> shamt;
            F_EQ:  simple_res = WORD_SIZE'(a == b);
            F_NEQ: simple_res = WORD_SIZE'(a != b);
            F_LT:  simple_res = WORD_SIZE'($signed(a) <  $signed(b));
            F_LEQ: simple_res = WORD_SIZE'($signed(a) <= $signed(b));
            default: simple_ill = 1'b1;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        div_zero <= 1'b0;
                        illegal  <= simple_ill;
                        cnt      <= '0;
                        acc      <= '0;
                        if (func == F_DIV) begin
                            if (b == '0) begin
                                result    <= '1;
                                remainder <= a;
                                div_zero  <= 1'b1;
                                done      <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                op_a  <= mag(a);
                                op_b  <= mag(b);
                                neg_q <= a[WORD_SIZE-1] ^ b[WORD_SIZE-1];
                                neg_r <= a[WORD_SIZE-1];
                                busy  <= 1'b1;
                                state <= S_DIV;
                            end
                        end else if (func == F_MLT) begin
`ifdef NIU32_MC_ALU_FAST_MUL_EN
                            result    <= simple_res;
                            remainder <= '0;
                            done      <= 1'b1;
                            state     <= S_DONE;
`else
                            op_a  <= a;
                            op_b  <= b;
                            busy  <= 1'b1;
                            state <= S_MUL;
`endif
                        end else begin
                            result    <= simple_res;
                            remainder <= '0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
`ifndef NIU32_MC_ALU_FAST_MUL_EN
                S_MUL: begin
                    acc  <= mul_next;
                    op_a <= op_a << 1;
                    op_b <= op_b >> 1;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        result    <= mul_next;
                        remainder <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DIV: begin
                    cnt <= cnt + 1'b1;
                    if (!div_diff[WORD_SIZE]) begin
                        acc  <= div_diff[WORD_SIZE-1:0];
                        op_a <= {op_a[WORD_SIZE-2:0], 1'b1};
                    end else begin
                        acc  <= div_shift[WORD_SIZE-1:0];
                        op_a <= {op_a[WORD_SIZE-2:0], 1'b0};
                    end
                    if (last_iter) state <= S_DIV_FIX;
                end
                S_DIV_FIX: begin
                    result    <= neg_q ? -op_a : op_a;
                    remainder <= neg_r ? -acc : acc;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_niu32_mc_alu.sv
// Self-checking bench for niu32_mc_alu: directed corner cases plus randomized ops
// compared against an arithmetic reference model (honours NIU32_MC_ALU_FAST_MUL_EN).
module tb_niu32_mc_alu;

`ifdef NIU32_MC_ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        div_zero;
    logic        illegal;

    int n_vec  = 0;
    int n_miss = 0;

    niu32_mc_alu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .func      (func),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void model(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] m,
                                  output logic z, output logic il, output int lat);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0; m = '0; z = 1'b0; il = 1'b0; lat = 1;
        case (f)
            5'd0:  r = x - y;
            5'd1:  r = x + y;
            5'd2:  begin r = 32'(sx * sy); lat = MUL_LAT; end
            5'd3:  if (y == 32'd0) begin r = '1; m = x; z = 1'b1; end
                   else begin r = 32'(sx / sy); m = 32'(sx % sy); lat = 34; end
            5'd4:  r = ~x;
            5'd5:  r = x & y;
            5'd6:  r = x | y;
            5'd7:  r = x ^ y;
            5'd8, 5'd9: r = x << y[4:0];
            5'd10: r = x >> y[4:0];
            5'd11: r = 32'(sx >>> y[4:0]);
            5'd16: r = {31'd0, sx == sy};
            5'd17: r = {31'd0, sx != sy};
            5'd18: r = {31'd0, sx <  sy};
            5'd19: r = {31'd0, sx <= sy};
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one op, scramble inputs after acceptance, then check latency, busy time, outputs.
    task automatic run_op(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] er, em;
        logic        ez, ei;
        int          el, lat, busy_cnt;
        model(f, x, y, er, em, ez, ei, el);
        @(negedge clk);
        start = 1'b1; func = f; a = x; b = y;
        lat = 0; busy_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; a = $urandom; b = $urandom; func = 5'($urandom);
            end
            if (done) begin lat = k; break; end
            if (busy) busy_cnt++;
        end
        check({tag, ".lat"},  32'(lat), 32'(el));
        check({tag, ".busy"}, 32'(busy_cnt), 32'(el - 1));
        check({tag, ".res"},  result, er);
        check({tag, ".rem"},  remainder, em);
        check({tag, ".dz"},   32'(div_zero), 32'(ez));
        check({tag, ".ill"},  32'(illegal), 32'(ei));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic        seen;
        int          lat;
        logic [4:0]  rf;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.res",  result, 32'd0);
        check("rst.rem",  remainder, 32'd0);
        check("rst.dz",   32'(div_zero), 32'd0);
        check("rst.ill",  32'(illegal), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a division aborts it silently.
        run_op(5'd1, 32'd100, 32'd23, "pre");
        @(negedge clk);
        start = 1'b1; func = 5'd3; a = -32'sd7; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.res",  result, 32'd0);
        check("abort.rem",  remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort.nodone", 32'(seen), 32'd0);
        run_op(5'd1, 32'd3, 32'd4, "add");
        check("add.lit", result, 32'd7);

        run_op(5'd2, -32'sd6, 32'd7, "mlt");
        check("mlt.lit", result, 32'hFFFF_FFD6);
        run_op(5'd3, -32'sd7, 32'd2, "div");
        check("div.lit.q", result, 32'hFFFF_FFFD);
        check("div.lit.r", remainder, 32'hFFFF_FFFF);
        run_op(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divmin");
        check("divmin.lit", result, 32'h8000_0000);
        run_op(5'd3, 32'd5, 32'd0, "div0");
        check("div0.lit", result, 32'hFFFF_FFFF);
        run_op(5'd1, 32'd1, 32'd1, "add_clr");
        run_op(5'd11, 32'h8000_0000, 32'h24, "ssr");
        check("ssr.lit", result, 32'hF800_0000);
        run_op(5'd10, 32'h8000_0000, 32'h24, "sur");
        check("sur.lit", result, 32'h0800_0000);
        run_op(5'd18, 32'hFFFF_FFFF, 32'd1, "lt");
        run_op(5'd13, 32'd9, 32'd9, "ill13");
        run_op(5'd4, 32'h1234_5678, 32'hFFFF_FFFF, "not");

        // start held high through a multiply: only the first request executes.
        @(negedge clk);
        start = 1'b1; func = 5'd2; a = -32'sd6; b = 32'd7;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin lat = k; start = 1'b0; break; end
            a = $urandom; b = $urandom; func = 5'($urandom_range(0, 19));
        end
        start = 1'b0;
        check("spam.lat", 32'(lat), 32'(MUL_LAT));
        check("spam.res", result, 32'hFFFF_FFD6);
        @(negedge clk);
        check("spam.pulse", 32'(done), 32'd0);

        // Back-to-back: new start on the cycle done is high.
        @(negedge clk);
        start = 1'b1; func = 5'd1; a = 32'd10; b = 32'd20;
        @(negedge clk);
        check("b2b.done1", 32'(done), 32'd1);
        check("b2b.res1",  result, 32'd30);
        func = 5'd7; a = 32'hF0F0_0000; b = 32'h0FF0_1234;
        @(negedge clk);
        start = 1'b0;
        check("b2b.done2", 32'(done), 32'd1);
        check("b2b.res2",  result, 32'hFF00_1234);
        @(negedge clk);

        // Randomized operations, biased toward small operands and corner values sometimes.
        for (int i = 0; i < 60; i++) begin
            rf = 5'($urandom_range(0, 31));
            if (i % 3 == 0) rf = 5'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = 32'($signed(8'($urandom)));
            if (i % 7 == 2) rb = '0;
            if (i % 11 == 5) ra = 32'h8000_0000;
            run_op(rf, ra, rb, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
